// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Launches MEM-stage loads/stores onto an SRAM-like req/addr_ok/data_ok bus.
// Only one transaction is outstanding at a time. Request fields are held
// stable while req is high. Flushed transactions run to completion on the bus,
// and their responses are dropped. A saturating counter tracks stall cycles.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  // MEM stage side
  input  logic                mem_valid,
  input  logic                mem_we,
  input  logic [1:0]          mem_size,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_flush,
  input  logic                wb_allowin,
  output logic                mem_ready,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_stall,
  output logic [CNT_W-1:0]    perf_stall_cnt,
  // data bus side
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [1:0]          data_sram_size,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [DATA_W/8-1:0] data_sram_wstrb,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic                data_sram_addr_ok,
  input  logic                data_sram_data_ok,
  input  logic [DATA_W-1:0]   data_sram_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                cancel_q, cancel_d;
  logic                req_q, req_d;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                launch_s;
  logic                resp_s;
  logic                done_s;
  logic                cnt_sat_s;

  // A new access launches only from IDLE, never during a flush, and never
  // while a cancelled transaction is still owed its data_ok.
  assign launch_s  = (state_q == S_IDLE) & mem_valid & ~mem_flush & ~cancel_q;
  // Any data_ok seen while waiting for data closes the bus transaction.
  assign resp_s    = (state_q == S_DATA) & data_sram_data_ok;
  // Only a response belonging to a live (uncancelled) instruction is delivered.
  assign done_s    = resp_s & ~cancel_q;
  assign cnt_sat_s = &cnt_q;

  // Result handshake: completion passes through live, and HOLD replays it.
  assign mem_ready = done_s | (state_q == S_HOLD);
  assign mem_rdata = done_s ? data_sram_rdata : rdata_q;
  assign mem_stall = mem_valid & ~mem_flush & ~(mem_ready & wb_allowin);

  assign perf_stall_cnt  = cnt_q;
  assign data_sram_req   = req_q;
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;

  // Next-state logic for the bus sequencer, cancel flag and request line.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    req_d    = req_q;
    case (state_q)
      S_IDLE: begin
        if (launch_s) begin
          state_d = S_ADDR;
          req_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        // The request must stay on the bus even if the instruction is flushed.
        if (mem_flush) begin
          cancel_d = 1'b1;
        end else begin
          cancel_d = cancel_q;
        end
        if (data_sram_addr_ok) begin
          state_d = S_DATA;
          req_d   = 1'b0;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (resp_s) begin
          // Transaction closed on the bus. Any pending cancel is now settled.
          cancel_d = 1'b0;
          if (done_s & ~mem_flush & ~wb_allowin) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end else if (mem_flush) begin
          cancel_d = 1'b1;
          state_d  = S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_HOLD: begin
        // A flush while holding drops the result; otherwise wait for WB.
        if (wb_allowin | mem_flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cancel_d = 1'b0;
        req_d    = 1'b0;
      end
    endcase
  end

  // Capture load data on a live completion, and update the stall counter.
  always_comb begin
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    if (done_s) begin
      rdata_d = data_sram_rdata;
    end else begin
      rdata_d = rdata_q;
    end
    if (mem_stall & ~cnt_sat_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, request registers, captured data and counter, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= {ADDR_W{1'b0}};
      wstrb_q  <= {STRB_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      rdata_q  <= {DATA_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      if (launch_s) begin
        wr_q    <= mem_we;
        size_q  <= mem_size;
        addr_q  <= mem_addr;
        wstrb_q <= mem_wstrb;
        wdata_q <= mem_wdata;
      end
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage load/store operations onto the SRAM-like data bus (req / addr_ok / data_ok handshake) with at most one transaction outstanding.
- The MEM stage has already produced the byte enables and the aligned store data; this block launches the transaction, holds it stable, and returns load data.
- It stalls the pipeline while busy and absorbs exception flushes without breaking the bus protocol.
- It also keeps a saturating stall-cycle performance counter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a valid load/store.
- mem_we  in  1  1 = store, 0 = load.
- mem_size  in  2  0 = byte, 1 = half, 2 = word.
- mem_addr  in  ADDR_W  access address.
- mem_wstrb  in  DATA_W/8  byte enables from the store formatter.
- mem_wdata  in  DATA_W  aligned store data.
- mem_flush  in  1  exception/ERET flush of the MEM instruction.
- wb_allowin  in  1  WB stage can accept the result.
- mem_ready  out  1  access finished; mem_rdata is valid.
- mem_rdata  out  DATA_W  load data.
- mem_stall  out  1  stall the MEM stage.
- perf_stall_cnt  out  CNT_W  saturating count of stall cycles.
- data_sram_req  out  1  bus request.
- data_sram_wr  out  1  bus write.
- data_sram_size  out  2  bus size.
- data_sram_addr  out  ADDR_W  bus address.
- data_sram_wstrb  out  DATA_W/8  bus byte strobes.
- data_sram_wdata  out  DATA_W  bus write data.
- data_sram_addr_ok  in  1  slave accepted the address.
- data_sram_data_ok  in  1  slave returned data / write acknowledge.
- data_sram_rdata  in  DATA_W  read data.

Behaviour:
- Reset values: state=IDLE, cancel=0, all data_sram_* outputs 0, mem_ready=0, mem_rdata=0, perf_stall_cnt=0. A reset mid-transaction returns to IDLE immediately; a data_ok still in flight after reset is ignored.
- The FSM has four states: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - When mem_valid & ~mem_flush & ~cancel, latch we/size/addr/wstrb/wdata into the request registers and go to ADDR.
  - No same-cycle issue: req first appears in the cycle after launch.
- ADDR:
  - data_sram_req=1 and all request fields are held stable every cycle, including when a flush arrives.
  - On addr_ok, go to DATA with req deasserted that same edge.
- DATA:
  - req=0. data_ok in the same cycle as addr_ok is illegal on this bus and is not handled.
  - On data_ok with cancel=0: mem_ready=1 combinationally and mem_rdata=data_sram_rdata passes through; the register also captures it. Then go to IDLE if wb_allowin, else go to HOLD.
  - On data_ok with cancel=1: mem_ready stays 0, cancel is cleared, go to IDLE.
- HOLD:
  - mem_ready=1 and mem_rdata holds the captured value.
  - Go to IDLE when wb_allowin or mem_flush. A flush in HOLD drops the result.
- Flush in ADDR or DATA sets cancel=1; the bus transaction still completes and its response is discarded.
- Flush in IDLE: nothing launches.
- New mem_valid while cancel=1: held in IDLE (stalled) until the cancelled data_ok arrives.
- mem_stall = mem_valid & ~mem_flush & ~(mem_ready & wb_allowin).
- perf_stall_cnt increments by 1 each cycle mem_stall=1 and saturates at all-ones.
- Minimum load latency: launch at edge T, req in cycle T+1, addr_ok in T+1, data_ok and mem_ready in T+2. Next issue is possible at T+3.
- Stores use the same flow; mem_rdata content is don't-care for stores, but mem_ready follows the same rules.

Test Plan:
- Load word at 0x1000_0004; slave gives addr_ok in the req cycle and data_ok next cycle with 0xDEADBEEF.
  - Required: req high exactly 1 cycle with wr=0, size=2.
  - Required: mem_ready=1 and mem_rdata=0xDEADBEEF one cycle later; perf_stall_cnt=2.
- Store half with wstrb=0b1100, wdata=0xABCD0000; addr_ok delayed 3 cycles.
  - Required: req/addr/wstrb/wdata stable for all 4 req cycles.
  - Required: mem_ready on data_ok, then return to IDLE.
- Load completes with wb_allowin=0 for 2 cycles.
  - Required: HOLD state, mem_ready=1, mem_rdata constant for 2 cycles, then IDLE the cycle after wb_allowin=1.
- mem_flush during ADDR with addr_ok delayed.
  - Required: req stays high until addr_ok.
  - Required: at data_ok, mem_ready=0; a new mem_valid is stalled until that data_ok, then launches.
- Back-to-back loads to 0x0 and 0x4 with a zero-wait slave.
  - Required: second req begins exactly 2 cycles after the first data_ok cycle; both results are correct.
- Reset asserted while in DATA.
  - Required: all outputs return to 0 next cycle, a late data_ok is ignored, and perf_stall_cnt=0.
